// File: rtl/audio_sample_streamer.sv
// rtl/audio_sample_streamer.sv - fetches PCM samples from sample memory, attenuates them and feeds the serializer FIFO
module audio_sample_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [3:0]            atten,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  fifo_half_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] audio_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic                  loop_q;
  logic                  at_end;
  logic [DATA_WIDTH-1:0] shifted;

  assign at_end   = (addr == end_q);
  assign mem_addr = addr;
  // Sign-extending shift: full attenuation leaves negative samples at -1, not 0.
  assign shifted  = DATA_WIDTH'($signed(mem_rdata) >>> atten);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (stop) begin
          next_state = S_IDLE;
        end else if (!fifo_half_full) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop || (at_end && !loop_q)) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_FETCH;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state == S_FETCH) && !stop && !fifo_half_full;
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr       <= '0;
      start_q    <= '0;
      end_q      <= '0;
      loop_q     <= 1'b0;
      audio_data <= '0;
      fifo_wr_en <= 1'b0;
      done       <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr    <= start_addr;
            start_q <= start_addr;
            end_q   <= end_addr;
            loop_q  <= loop_en;
          end
        end
        S_WAIT: begin
          // A stop here drops the in-flight sample entirely.
          if (!stop) begin
            audio_data <= shifted;
            fifo_wr_en <= 1'b1;
            if (at_end) begin
              if (loop_q) begin
                addr <= start_q;
              end else begin
                done <= 1'b1;
              end
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// tb/tb_audio_sample_streamer.sv - directed self-checking bench for audio_sample_streamer
module tb_audio_sample_streamer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic [3:0]  atten = '0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        fifo_half_full = 1'b0;
  logic        fifo_wr_en;
  logic [15:0] audio_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int mem_mode = 0;

  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  logic [15:0] rd_addr[$];
  int          rd_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b0;

  audio_sample_streamer #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .atten(atten),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fifo_half_full(fifo_half_full), .fifo_wr_en(fifo_wr_en),
    .audio_data(audio_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sample memory: data = {addr[7:0], addr[7:0]}, or alternating 0x8000/0x7FFF.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (mem_mode == 1) mem_rdata <= mem_addr[0] ? 16'h7FFF : 16'h8000;
      else               mem_rdata <= {mem_addr[7:0], mem_addr[7:0]};
    end
  end

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (fifo_wr_en) begin
      wr_data.push_back(audio_data);
      wr_cyc.push_back(cyc_n);
    end
    if (mem_rd_en) begin
      rd_addr.push_back(mem_addr);
      rd_cyc.push_back(cyc_n);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc_n;
      busy_at_done = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_data.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic start_play(input logic [15:0] sa, input logic [15:0] ea, input logic le);
    start = 1'b1; start_addr = sa; end_addr = ea; loop_en = le;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({mem_addr, mem_rd_en, fifo_wr_en, audio_data, busy, done} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state: got addr=%h rd=%b wr=%b data=%h busy=%b done=%b, want all 0",
               mem_addr, mem_rd_en, fifo_wr_en, audio_data, busy, done);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_one_shot();
    logic [15:0] exp_d[4] = '{16'h1010, 16'h1111, 16'h1212, 16'h1313};
    clear_logs();
    mem_mode = 0; atten = 4'd0;
    start_play(16'h0010, 16'h0013, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch: busy=%b rd=%b, want 1 1", busy, mem_rd_en);
    end
    wait_done();
    n_checks++;
    if (wr_data.size() != 4 || done_cnt != 1) begin
      n_fail++; $display("FAIL one_shot_count: writes=%0d done=%0d, want 4 1", wr_data.size(), done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wr_data[i] !== exp_d[i] || rd_addr[i] !== 16'h0010 + 16'(i)) begin
          n_fail++;
          $display("FAIL one_shot_data%0d: data=%h addr=%h, want %h %h", i, wr_data[i], rd_addr[i], exp_d[i], 16'h0010 + 16'(i));
        end
        n_checks++;
        if (wr_cyc[i] - rd_cyc[i] != 2 || (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 2)) begin
          n_fail++; $display("FAIL one_shot_timing%0d: rd@%0d wr@%0d, want latency 2 spacing 2", i, rd_cyc[i], wr_cyc[i]);
        end
      end
      n_checks++;
      if (done_cyc != wr_cyc[3] || busy_at_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL one_shot_done: done@%0d last_wr@%0d busy_at_done=%b busy=%b, want same cycle busy 0",
                 done_cyc, wr_cyc[3], busy_at_done, busy);
      end
    end
  endtask

  task automatic test_loop_stop();
    int n_wr;
    int seen;
    clear_logs();
    start_play(16'h0005, 16'h0006, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_rd_en) seen = 1; else tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || seen == 0) begin
      n_fail++; $display("FAIL loop_stop_idle: busy=%b fetch_seen=%0d, want 0 1", busy, seen);
    end
    n_wr = wr_data.size();
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (wr_data.size() != n_wr || done_cnt != 0) begin
      n_fail++; $display("FAIL loop_after_stop: writes %0d->%0d done=%0d, want no change 0", n_wr, wr_data.size(), done_cnt);
    end
    n_checks++;
    if (rd_addr.size() < 4 || rd_addr[0] !== 16'h5 || rd_addr[1] !== 16'h6 || rd_addr[2] !== 16'h5 || rd_addr[3] !== 16'h6
        || wr_data[2] !== 16'h0505) begin
      n_fail++; $display("FAIL loop_addrs: n=%0d first=%h,%h,%h,%h, want 5,6,5,6", rd_addr.size(),
                         rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]);
    end
  endtask

  task automatic test_atten();
    logic [3:0]  at[2]   = '{4'd1, 4'd15};
    logic [15:0] e_lo[2] = '{16'hC000, 16'hFFFF};
    logic [15:0] e_hi[2] = '{16'h3FFF, 16'h0000};
    mem_mode = 1;
    for (int k = 0; k < 2; k++) begin
      clear_logs();
      atten = at[k];
      start_play(16'h0020, 16'h0021, 1'b0);
      wait_done();
      n_checks++;
      if (wr_data.size() != 2 || wr_data[0] !== e_lo[k] || wr_data[1] !== e_hi[k]) begin
        n_fail++; $display("FAIL atten%0d: n=%0d got %h %h, want %h %h", at[k], wr_data.size(), wr_data[0], wr_data[1], e_lo[k], e_hi[k]);
      end
    end
    mem_mode = 0; atten = 4'd0;
  endtask

  task automatic test_backpressure();
    int rd_hi;
    clear_logs();
    fifo_half_full = 1'b1;
    start_play(16'h0040, 16'h0040, 1'b0);
    rd_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_en || !busy) rd_hi++;
      tick();
    end
    n_checks++;
    if (rd_hi != 0 || wr_data.size() != 0) begin
      n_fail++; $display("FAIL bp_hold: rd_or_idle_cycles=%0d writes=%0d, want 0 0", rd_hi, wr_data.size());
    end
    fifo_half_full = 1'b0;
    wait_done();
    n_checks++;
    if (rd_cyc.size() != 1 || wr_cyc.size() != 1 || wr_cyc[0] - rd_cyc[0] != 2 || wr_data[0] !== 16'h4040) begin
      n_fail++; $display("FAIL bp_release: reads=%0d writes=%0d data=%h, want 1 1 4040 latency 2",
                         rd_cyc.size(), wr_cyc.size(), wr_data[0]);
    end
  endtask

  task automatic test_edges();
    clear_logs();
    start_play(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done();
    n_checks++;
    if (wr_data.size() != 1 || wr_data[0] !== 16'hFFFF || done_cnt != 1) begin
      n_fail++; $display("FAIL single_ffff: writes=%0d data=%h done=%0d, want 1 ffff 1", wr_data.size(), wr_data[0], done_cnt);
    end
    clear_logs();
    start_play(16'hFFFE, 16'h0001, 1'b0);
    wait_done();
    n_checks++;
    if (wr_data.size() != 4 || rd_addr[0] !== 16'hFFFE || rd_addr[1] !== 16'hFFFF || rd_addr[2] !== 16'h0000
        || rd_addr[3] !== 16'h0001 || wr_data[3] !== 16'h0101) begin
      n_fail++; $display("FAIL wrap: writes=%0d addrs=%h,%h,%h,%h, want 4 fffe,ffff,0000,0001",
                         wr_data.size(), rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]);
    end
    clear_logs();
    start_play(16'h0050, 16'h0053, 1'b0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wr_data.size() != 0 || busy !== 1'b0 || done_cnt != 0) begin
      n_fail++; $display("FAIL stop_in_wait: writes=%0d busy=%b done=%0d, want 0 0 0", wr_data.size(), busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    start_play(16'h0010, 16'h0013, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({mem_addr, mem_rd_en, fifo_wr_en, audio_data, busy, done} !== 35'd0 || wr_data.size() == 0) begin
      n_fail++;
      $display("FAIL reset_mid: addr=%h rd=%b wr=%b data=%h busy=%b done=%b prior_writes=%0d, want all 0 and prior>0",
               mem_addr, mem_rd_en, fifo_wr_en, audio_data, busy, done, wr_data.size());
    end
    reset_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after: done=%0d busy=%b, want 0 0", done_cnt, busy);
    end
  endtask

  task automatic test_start_busy();
    clear_logs();
    start_play(16'h0060, 16'h0063, 1'b0);
    tick();
    start = 1'b1; start_addr = 16'h0000; end_addr = 16'h0001;
    tick();
    start = 1'b0;
    wait_done();
    n_checks++;
    if (wr_data.size() != 4 || rd_addr[0] !== 16'h0060 || rd_addr[3] !== 16'h0063 || wr_data[3] !== 16'h6363) begin
      n_fail++; $display("FAIL start_busy: writes=%0d first=%h last=%h, want 4 0060 0063",
                         wr_data.size(), rd_addr[0], rd_addr[3]);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_loop_stop();
    test_atten();
    test_backpressure();
    test_edges();
    test_reset_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_streamer.md
# audio_sample_streamer

Upstream feeder for the I2S audio serializer. Fetches mono PCM samples from a synchronous sample memory between a programmed start and end address. Applies a right-shift attenuation and pushes each sample into the serializer's sample FIFO, throttled by that FIFO's half-full flag. Supports one-shot and looped playback, with start/stop control from the CPU-side register interface.

## Interface
- DATA_WIDTH, 16, sample width; matches serializer FIFO width
- ADDR_WIDTH, 16, sample memory address width
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins playback; ignored while busy
- stop  in  1  one-cycle pulse; aborts playback; ignored while idle
- loop_en  in  1  sampled on start; 1 = restart at start_addr after end_addr
- start_addr  in  ADDR_WIDTH  first sample address; sampled on start
- end_addr  in  ADDR_WIDTH  last sample address, inclusive; sampled on start
- atten  in  4  arithmetic right-shift applied to each sample; sampled live in WAIT
- mem_rd_en  out  1  sample memory read strobe
- mem_addr  out  ADDR_WIDTH  sample memory address (registered)
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en
- fifo_half_full  in  1  serializer FIFO half-full flag
- fifo_wr_en  out  1  registered one-cycle FIFO write strobe
- audio_data  out  DATA_WIDTH  registered sample to FIFO
- busy  out  1  high in any state other than IDLE
- done  out  1  registered one-cycle pulse at natural end of one-shot playback

## Operation
- States: IDLE, FETCH, WAIT.
- IDLE
  - On start: addr <= start_addr.
  - Latch end_addr and loop_en.
  - Go to FETCH.
- FETCH
  - If stop: go to IDLE.
  - Else if !fifo_half_full: mem_rd_en = 1 (combinational, FETCH only) and go to WAIT.
  - Else stay in FETCH with mem_rd_en = 0.
- WAIT: mem_rdata is valid this cycle.
  - If stop: discard the data, no write, go to IDLE.
  - Else: register audio_data <= $signed(mem_rdata) >>> atten and fifo_wr_en <= 1.
  - Then, if addr == end_addr:
    - loop_en latched 1: addr <= start_addr, go to FETCH.
    - loop_en latched 0: done <= 1, go to IDLE.
  - Otherwise: addr <= addr + 1 (wraps modulo 2^ADDR_WIDTH) and go to FETCH.
- mem_addr is the addr register output at all times.
- fifo_wr_en and done are 0 in every cycle not listed above.
- audio_data holds its last value between writes.
- Attenuation: sign-extending shift. atten = 15 maps positive samples to 0 and negative samples to -1 (0xFFFF at width 16).
- start_addr == end_addr: exactly one sample per pass.
- start_addr > end_addr: addresses ascend through wrap-around up to end_addr.
- start and stop in the same IDLE cycle: start wins.
- fifo_full is not monitored. One outstanding read plus the half-full gating leaves at least DEPTH/2 - 1 free entries.

## Timing
- Reset values:
  - state IDLE
  - mem_addr 0, mem_rd_en 0
  - fifo_wr_en 0, audio_data 0
  - busy 0, done 0
- Reset mid-playback returns to IDLE next edge with no write and no done.
- start at cycle 0 → FETCH at cycle 1, busy = 1 at cycle 1.
- With half_full low:
  - mem_rd_en at cycle 1.
  - WAIT at cycle 2.
  - fifo_wr_en + audio_data at cycle 3, coincident with the next mem_rd_en.
- Sustained throughput: 1 sample per 2 clk while half_full is low.
- Latency from the mem_rd_en cycle to the fifo_wr_en cycle is 2 clk.
- fifo_half_full is sampled only in FETCH. If it rises during WAIT, the in-flight sample is still written.
- Final one-shot sample:
  - done and fifo_wr_en assert in the same cycle.
  - busy is already 0 in that cycle.
- A new start is accepted in that same cycle.

## Test plan
- One-shot, start_addr = 0x10, end_addr = 0x13, atten = 0, memory holds data = addr*0x0101, half_full = 0 → 4 writes: 0x1010, 0x1111, 0x1212, 0x1313, spaced 2 clk apart; done pulses once with the last write; busy falls.
- Loop, start = 5, end = 6, loop_en = 1 → mem_addr sequence 5, 6, 5, 6, …; stop in FETCH → IDLE next cycle, no further writes, done never asserts.
- Attenuation, samples 0x8000 and 0x7FFF:
  - atten = 1 → 0xC000 and 0x3FFF.
  - atten = 15 → 0xFFFF and 0x0000.
- Backpressure: hold half_full = 1 for 20 cycles in FETCH → mem_rd_en stays 0 and no writes; release → read next cycle, write 2 cycles later.
- Edge cases:
  - start = end = 0xFFFF → exactly one write.
  - start = 0xFFFE, end = 0x0001 → 4 writes, addresses FFFE, FFFF, 0000, 0001.
  - stop in WAIT → that sample is not written.
- Reset: reset_n low mid-playback → all outputs 0 next cycle; start while busy is ignored (addresses unchanged).
